ramp_adc_scheduler: RTL and testbench



---
 rtl/ramp_adc_scheduler_pkg.sv | 45 ++++
 rtl/ramp_adc_scheduler_rr_channel_picker.sv | 22 ++
 rtl/ramp_adc_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_ramp_adc_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramp_adc_scheduler_pkg.sv
// ramp_adc_pkg: shared types and helpers for the single-slope ramp ADC scheduler.
//   ramp_adc_state_e : scheduler FSM states
//   next_enabled_ch  : round-robin pick of the next enabled channel index
package ramp_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        RAMP,
        OUTPUT
    } ramp_adc_state_e;

    // Upper bound on channel count supported by the round-robin helper.
    localparam int MAX_CH   = 16;
    localparam int CH_IDX_W = 4;

    // Lowest enabled index strictly after 'last', wrapping modulo num_ch.
    // If 'last' is the only enabled channel it is picked again (i == num_ch).
    // Returns 'last' when the mask is empty; callers qualify with |mask.
    function automatic logic [CH_IDX_W-1:0] next_enabled_ch(
        input logic [MAX_CH-1:0]   mask,
        input logic [CH_IDX_W-1:0] last,
        input int                  num_ch
    );
        logic [CH_IDX_W:0]   idx;
        logic [CH_IDX_W-1:0] pick;
        logic                found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            // last < num_ch and i <= num_ch, so one conditional subtract wraps.
            idx = {1'b0, last} + (CH_IDX_W+1)'(i);
            if (idx >= (CH_IDX_W+1)'(num_ch)) begin
                idx = idx - (CH_IDX_W+1)'(num_ch);
            end
            if (!found && (i <= num_ch) && mask[idx[CH_IDX_W-1:0]]) begin
                pick  = idx[CH_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ramp_adc_scheduler_rr_channel_picker.sv
// rr_channel_picker: combinational round-robin next-enabled-index finder.
// Ports:
//   mask_i  : per-requester enable mask
//   last_i  : index served most recently
//   pick_o  : lowest enabled index strictly after last_i (wrapping)
//   any_o   : 1 when at least one requester is enabled
module rr_channel_picker
    import ramp_adc_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [IDX_W-1:0]  last_i,
    output logic [IDX_W-1:0]  pick_o,
    output logic              any_o
);

    assign pick_o = IDX_W'(next_enabled_ch(MAX_CH'(mask_i), CH_IDX_W'(last_i), NUM_CH));
    assign any_o  = |mask_i;

endmodule

// File: rtl/ramp_adc_scheduler.sv
// ramp_adc_scheduler: multi-channel single-slope ADC sequencer. Walks enabled
// channels round-robin, drives the analog mux, holds the PWM duty at 0 while
// the RC filter settles, ramps the duty and captures it when the synchronized
// comparator trips (or saturates at MAX). Samples leave on a valid/ready port.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   run           : level, convert continuously while high
//   ch_enable     : per-channel enable mask (sampled in SELECT only)
//   comp_in       : async comparator, 1 while ramp < selected input
//   ch_sel        : analog mux select
//   duty_cycle    : duty code to the pwm instance
//   busy          : high whenever not IDLE
//   sample_data   : captured code
//   sample_ch     : channel of sample_data
//   sample_valid  : sample available (registered, no ready->valid path)
//   sample_ready  : consumer accepts
//   sample_sat    : only with RAMP_ADC_SAT_FLAG_EN; 1 when the sample saturated
module ramp_adc_scheduler
    import ramp_adc_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int NUM_CH        = 5,
    parameter int STEP_PERIOD   = 1024,
    parameter int SETTLE_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic                      comp_in,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic [WIDTH-1:0]          duty_cycle,
    output logic                      busy,
    output logic [WIDTH-1:0]          sample_data,
    output logic [$clog2(NUM_CH)-1:0] sample_ch,
    output logic                      sample_valid,
    input  logic                      sample_ready
`ifdef RAMP_ADC_SAT_FLAG_EN
    ,
    output logic                      sample_sat
`endif
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int STEP_W = $clog2(STEP_PERIOD + 1);
    localparam logic [WIDTH-1:0] DUTY_MAX = '1;

    ramp_adc_state_e    state_q, state_d;
    logic               sync1_q, comp_s_q;
    logic [CH_W-1:0]    last_ch_q, last_ch_d;
    logic [CH_W-1:0]    ch_sel_q, ch_sel_d;
    logic [WIDTH-1:0]   duty_q, duty_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CH_W-1:0]    sch_q, sch_d;
    logic               valid_q, valid_d;
`ifdef RAMP_ADC_SAT_FLAG_EN
    logic               sat_q, sat_d;
`endif
    logic [CH_W-1:0]    pick;
    logic               pick_any;

    rr_channel_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_picker (
        .mask_i (ch_enable),
        .last_i (last_ch_q),
        .pick_o (pick),
        .any_o  (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            // Synchronizer idles at "ramp below input" so no false trip.
            sync1_q   <= 1'b1;
            comp_s_q  <= 1'b1;
            // Starting from the last index makes channel 0 the first pick.
            last_ch_q <= CH_W'(NUM_CH - 1);
            ch_sel_q  <= '0;
            duty_q    <= '0;
            settle_q  <= '0;
            step_q    <= '0;
            data_q    <= '0;
            sch_q     <= '0;
            valid_q   <= 1'b0;
`ifdef RAMP_ADC_SAT_FLAG_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= comp_in;
            comp_s_q  <= sync1_q;
            last_ch_q <= last_ch_d;
            ch_sel_q  <= ch_sel_d;
            duty_q    <= duty_d;
            settle_q  <= settle_d;
            step_q    <= step_d;
            data_q    <= data_d;
            sch_q     <= sch_d;
            valid_q   <= valid_d;
`ifdef RAMP_ADC_SAT_FLAG_EN
            sat_q     <= sat_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        last_ch_d = last_ch_q;
        ch_sel_d  = ch_sel_q;
        duty_d    = duty_q;
        settle_d  = settle_q;
        step_d    = step_q;
        data_d    = data_q;
        sch_d     = sch_q;
        valid_d   = valid_q;
`ifdef RAMP_ADC_SAT_FLAG_EN
        sat_d     = sat_q;
`endif
        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (run && (|ch_enable)) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                // The mask may have cleared since IDLE looked at it.
                if (pick_any) begin
                    ch_sel_d = pick;
                    settle_d = SET_W'(SETTLE_CYCLES - 1);
                    state_d  = SETTLE;
                end else begin
                    state_d  = IDLE;
                end
            end
            SETTLE: begin
                duty_d = '0;
                if (settle_q == '0) begin
                    step_d  = STEP_W'(STEP_PERIOD - 1);
                    state_d = RAMP;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            RAMP: begin
                // Trip wins over a saturating step tick in the same cycle.
                if (!comp_s_q) begin
                    data_d  = duty_q;
                    sch_d   = ch_sel_q;
                    valid_d = 1'b1;
                    duty_d  = '0;
                    state_d = OUTPUT;
`ifdef RAMP_ADC_SAT_FLAG_EN
                    sat_d   = 1'b0;
`endif
                end else if (step_q == '0) begin
                    if (duty_q == DUTY_MAX) begin
                        data_d  = DUTY_MAX;
                        sch_d   = ch_sel_q;
                        valid_d = 1'b1;
                        duty_d  = '0;
                        state_d = OUTPUT;
`ifdef RAMP_ADC_SAT_FLAG_EN
                        sat_d   = 1'b1;
`endif
                    end else begin
                        duty_d = duty_q + WIDTH'(1);
                        step_d = STEP_W'(STEP_PERIOD - 1);
                    end
                end else begin
                    step_d = step_q - STEP_W'(1);
                end
            end
            OUTPUT: begin
                duty_d = '0;
                if (valid_q && sample_ready) begin
                    valid_d   = 1'b0;
                    last_ch_d = sch_q;
                    state_d   = run ? SELECT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ch_sel       = ch_sel_q;
    assign duty_cycle   = duty_q;
    assign busy         = (state_q != IDLE);
    assign sample_data  = data_q;
    assign sample_ch    = sch_q;
    assign sample_valid = valid_q;
`ifdef RAMP_ADC_SAT_FLAG_EN
    assign sample_sat   = sat_q;
`endif

endmodule

// File: tb/tb_ramp_adc_scheduler.sv
// Scoreboard bench for ramp_adc_scheduler (WIDTH=8, NUM_CH=5, STEP_PERIOD=2,
// SETTLE_CYCLES=4). Each analog input is modelled as a threshold code: the
// comparator reads 1 while the duty code is below it; 256 means never trips.
module tb_ramp_adc_scheduler;

    localparam int WIDTH         = 8;
    localparam int NUM_CH        = 5;
    localparam int STEP_PERIOD   = 2;
    localparam int SETTLE_CYCLES = 4;
    localparam int CH_W          = 3;
    localparam int SAT_LAT       = SETTLE_CYCLES + 1 + 256 * STEP_PERIOD;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [NUM_CH-1:0] ch_enable;
    logic              comp_in;
    logic [CH_W-1:0]   ch_sel;
    logic [WIDTH-1:0]  duty_cycle;
    logic              busy;
    logic [WIDTH-1:0]  sample_data;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_valid;
    logic              sample_ready = 1'b1;
`ifdef RAMP_ADC_SAT_FLAG_EN
    logic              sample_sat;
`endif

    logic [8:0] thr [8];

    typedef struct {
        int ch;
        int lo;
        int hi;
        bit sat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   xfer_cnt = 0;
    int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    int   model_last = NUM_CH - 1;

    // monitor state
    bit              prev_valid = 1'b0;
    bit              prev_xfer = 1'b0;
    bit              prev_busy = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [CH_W-1:0] prev_sch;
    logic [CH_W-1:0] prev_sel;
    int              gap = 0;
    int              rise_gap = 0;

    always #5 clk = ~clk;

    assign comp_in = ({1'b0, duty_cycle} < thr[ch_sel]);

    ramp_adc_scheduler #(
        .WIDTH         (WIDTH),
        .NUM_CH        (NUM_CH),
        .STEP_PERIOD   (STEP_PERIOD),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .ch_enable    (ch_enable),
        .comp_in      (comp_in),
        .ch_sel       (ch_sel),
        .duty_cycle   (duty_cycle),
        .busy         (busy),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready)
`ifdef RAMP_ADC_SAT_FLAG_EN
        ,
        .sample_sat   (sample_sat)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Next channel: lowest enabled index after 'last', wrapping.
    function automatic int model_next(input logic [NUM_CH-1:0] mask, input int last);
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (last + k) % NUM_CH;
            if (mask[c]) return c;
        end
        return last;
    endfunction

    // Ready driver changes only just after the rising edge.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       sample_ready = 1'b1;
            1:       sample_ready = 1'($urandom_range(0, 1));
            default: sample_ready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every transfer.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
            prev_busy  = 1'b0;
            gap        = 0;
        end else begin
            if (prev_xfer || (busy && !prev_busy)) gap = 0;
            else gap++;
            if (prev_xfer) check("valid_one_cycle", int'(sample_valid), 0);
            if (sample_valid) begin
                if (!prev_valid) rise_gap = gap;
                check("duty_zero_in_output", int'(duty_cycle), 0);
                check("busy_in_output", int'(busy), 1);
                if (prev_valid && !prev_xfer) begin
                    check("data_stable", int'(sample_data), int'(prev_data));
                    check("ch_stable", int'(sample_ch), int'(prev_sch));
                    check("no_new_select", int'(ch_sel), int'(prev_sel));
                end
                if (sample_ready) begin
                    if (sb.size() == 0) begin
                        fail_now("unexpected_sample");
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("sample_ch", int'(sample_ch), e.ch);
                        check_rng("sample_data", int'(sample_data), e.lo, e.hi);
                        if (e.sat) check_rng("sat_latency", rise_gap, SAT_LAT - 3, SAT_LAT + 3);
`ifdef RAMP_ADC_SAT_FLAG_EN
                        check("sample_sat", int'(sample_sat), int'(e.sat));
`endif
                    end
                    xfer_cnt++;
                end
            end
            prev_valid = sample_valid;
            prev_xfer  = sample_valid && sample_ready;
            prev_busy  = busy;
            prev_data  = sample_data;
            prev_sch   = sample_ch;
            prev_sel   = ch_sel;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ch_sel", int'(ch_sel), 0);
        check("rst_duty", int'(duty_cycle), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_data", int'(sample_data), 0);
        check("rst_sch", int'(sample_ch), 0);
        check("rst_valid", int'(sample_valid), 0);
`ifdef RAMP_ADC_SAT_FLAG_EN
        check("rst_sat", int'(sample_sat), 0);
`endif
        @(negedge clk);
        reset      = 1'b0;
        sb.delete();
        model_last = NUM_CH - 1;
    endtask

    // Converts n samples with 'mask'; run drops once sample n is in flight.
    task automatic run_phase(input logic [NUM_CH-1:0] mask, input int n, input bit bp);
        int base;
        int t;
        int budget;
        bit ok;
        budget = 700 * n + 300;
        ch_enable = mask;
        for (int k = 0; k < n; k++) begin
            exp_t e;
            model_last = model_next(mask, model_last);
            e.ch = model_last;
            if (thr[model_last] > 9'd255) begin
                e.lo = 255; e.hi = 255; e.sat = 1'b1;
            end else begin
                e.lo = int'(thr[model_last]); e.hi = int'(thr[model_last]) + 1; e.sat = 1'b0;
            end
            sb.push_back(e);
        end
        base = xfer_cnt;
        ok   = 1'b1;
        if (bp) ready_mode = 2;
        @(negedge clk);
        run = 1'b1;
        if (bp) begin
            t = 0;
            while (!sample_valid && t < budget) begin @(negedge clk); t++; end
            if (!sample_valid) begin fail_now("timeout_bp_valid"); ok = 1'b0; end
            repeat (50) @(negedge clk);
            ready_mode = 0;
        end
        t = 0;
        while (ok && xfer_cnt < base + n - 1 && t < budget) begin @(negedge clk); t++; end
        if (ok && xfer_cnt < base + n - 1) begin fail_now("timeout_phase"); ok = 1'b0; end
        @(posedge clk);
        #1;
        run = 1'b0;
        t = 0;
        while (ok && (xfer_cnt < base + n || busy) && t < budget) begin @(negedge clk); t++; end
        if (ok) begin
            check("idle_after_stop", int'(busy), 0);
            check("transfer_count", xfer_cnt - base, n);
            check("scoreboard_drained", sb.size(), 0);
        end else begin
            do_reset();
        end
        ready_mode = 0;
    endtask

    initial begin
        int t;
        reset     = 1'b1;
        run       = 1'b0;
        ch_enable = '0;
        for (int i = 0; i < 8; i++) thr[i] = 9'd100;
        repeat (3) @(posedge clk);
        do_reset();

        // single channel, reconverted every time
        thr[0] = 9'd100;
        run_phase(5'b00001, 3, 1'b0);

        // round robin 1,2,4,1,2
        thr[1] = 9'd10; thr[2] = 9'd20; thr[4] = 9'd40;
        run_phase(5'b10110, 5, 1'b0);

        // saturation
        thr[3] = 9'd256;
        run_phase(5'b01000, 2, 1'b0);

        // backpressure
        thr[2] = 9'd30;
        run_phase(5'b00100, 1, 1'b1);

        // reset mid-RAMP discards the conversion
        thr[0] = 9'd256;
        ch_enable = 5'b00001;
        @(negedge clk);
        run = 1'b1;
        t = 0;
        while (duty_cycle != 8'd40 && t < 300) begin @(negedge clk); t++; end
        check("reached_duty_40", int'(duty_cycle), 40);
        do_reset();

        // empty mask keeps the FSM idle
        ch_enable = '0;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 5 == 4) check("empty_mask_idle", int'(busy), 0);
        end
        run = 1'b0;

        // randomized masks, thresholds and ready pattern
        for (int r = 0; r < 6; r++) begin
            logic [NUM_CH-1:0] m;
            m = NUM_CH'($urandom_range(1, 31));
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 9) == 0) thr[c] = 9'd256;
                else thr[c] = 9'($urandom_range(1, 250));
            end
            ready_mode = 1;
            run_phase(m, $urandom_range(2, 5), 1'b0);
        end

        check("final_scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
